// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly in front of the instruction decoder.
// It keeps the fetch PC and issues at most one word request at a time to
// instruction memory. Returned words are stored with their PCs in a small
// prefetch FIFO, and the FIFO head is offered to decode with a valid/ready
// handshake. A branch redirect flushes the FIFO and marks any in-flight
// response as stale, so that response is dropped when it arrives.
//
// Parameters
//   ADDR_W   : PC / instruction memory byte-address width
//   DEPTH    : prefetch FIFO entries (power of two, >= 2)
//   RESET_PC : fetch PC loaded on reset
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rst_n         : asynchronous active-low reset
//   imem_req      : one-cycle request strobe to instruction memory
//   imem_addr     : request address (current fetch PC)
//   imem_valid    : response strobe, at least one cycle after imem_req
//   imem_rdata    : response word, bit 0 = MSB
//   redirect      : branch/jump taken, restart fetch at redirect_pc
//   redirect_pc   : new fetch address, sampled with redirect
//   instr_valid   : FIFO head holds a word for decode
//   instr_out     : FIFO head word, bit 0 = MSB (decoder ordering)
//   pc_out        : PC of instr_out
//   decode_ready  : decoder takes the head word this cycle
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [0:31]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [0:31]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              decode_ready
);

  localparam int unsigned      PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // WAIT    : one request outstanding, its response is wanted.
  // DISCARD : one request outstanding, its response predates a redirect.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic issue;
  logic push;
  logic pop;
  logic fifo_nonempty;

  // FIFO storage: PC and word kept in parallel arrays, no reset needed
  // because an entry is only read once count says it was written.
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [0:31]       word_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_nonempty = (count_reg != '0);
    // A slot is reserved at issue time (count < DEPTH with nothing in
    // flight), so a wanted response can always be pushed. rst_n gates the
    // strobe so that no request is advertised while reset is held.
    issue = rst_n && (state_reg == IDLE) && (count_reg < FULL_COUNT) && !redirect;
    // Redirect overrides everything: the returning word is dropped and the
    // head is not consumed because the whole buffer is flushed anyway.
    push  = (state_reg == WAIT) && imem_valid && !redirect;
    pop   = fifo_nonempty && decode_ready && !redirect;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // imem_valid here is a protocol violation and is ignored.
        if (issue) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_next = imem_valid ? IDLE : DISCARD;
        end else if (imem_valid) begin
          state_next = IDLE;
        end
      end
      DISCARD: begin
        // Stale word dropped whether or not a new redirect arrives with it.
        if (imem_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;

    if (redirect) begin
      fetch_pc_next = redirect_pc;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (issue) begin
        req_pc_next   = fetch_pc_reg;
        // Natural modulo-2^ADDR_W wrap at the top of the address space.
        fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
      word_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_reg;
  assign instr_valid = fifo_nonempty;
  // Head is forced to zero when empty so that reset and flushed states read
  // 0 rather than whatever an old entry held.
  assign instr_out   = fifo_nonempty ? word_mem[rd_ptr_reg] : '0;
  assign pc_out      = fifo_nonempty ? pc_mem[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit: a table of hand-computed streaming vectors,
// hand-written sequences for backpressure, redirect, simultaneous events,
// address wrap and asynchronous reset, then randomized traffic. A queue-based
// reference model tracks the expected outputs on every cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [0:31]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [0:31]       instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              decode_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .decode_ready(decode_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: expected fetch PC, what is in flight, and the buffered
  // words in arrival order.
  typedef struct {
    logic [31:0] pc;
    logic [0:31] word;
  } entry_t;

  entry_t      m_fifo[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_stale;

  // Behavioural instruction memory.
  bit          mem_busy;
  int          mem_lat;
  int          mem_fixed_lat;
  logic [0:31] mem_word;

  // Outputs sampled in the most recent cycle.
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [0:31] s_instr;
  logic [31:0] s_pc;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        iv;
    logic [0:31] rw;
    logic        dr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [0:31] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pc     = '0;
    m_req_pc = '0;
    m_busy   = 0;
    m_stale  = 0;
    mem_busy = 0;
    mem_lat  = 0;
  endtask

  // One clock cycle: called at a falling edge, drives inputs, samples and
  // checks outputs against the model, advances the model, then returns at
  // the next falling edge.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic iv,
                       input logic [0:31] rw, input logic dr);
    bit exp_req;
    redirect     = rd;
    redirect_pc  = rpc;
    imem_valid   = iv;
    imem_rdata   = rw;
    decode_ready = dr;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_instr = instr_out;
    s_pc    = pc_out;

    exp_req = !m_busy && (m_fifo.size() < DEPTH) && !rd;
    check("imem_req", 32'(s_req), 32'(exp_req));
    check("imem_addr", s_addr, m_pc);
    check("instr_valid", 32'(s_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      check("pc_out", s_pc, m_fifo[0].pc);
      check("instr_out", s_instr, m_fifo[0].word);
    end

    if (rd) begin
      m_fifo.delete();
      m_pc = rpc;
      if (m_busy) begin
        m_stale = 1;
        m_busy  = !iv;
      end
    end else begin
      if (m_fifo.size() != 0 && dr) void'(m_fifo.pop_front());
      if (m_busy && iv) begin
        if (!m_stale) m_fifo.push_back('{m_req_pc, rw});
        m_busy = 0;
      end
      if (exp_req) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_busy   = 1;
        m_stale  = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle with the behavioural memory answering requests; spur injects a
  // response while nothing is outstanding.
  task automatic mem_cycle(input logic rd, input logic [31:0] rpc, input logic dr,
                           input logic spur);
    logic        iv;
    logic [0:31] rw;
    iv = 1'b0;
    rw = '0;
    if (mem_busy) begin
      mem_lat--;
      if (mem_lat == 0) begin
        iv       = 1'b1;
        rw       = mem_word;
        mem_busy = 0;
      end
    end else if (spur) begin
      iv = 1'b1;
      rw = $urandom;
    end
    cycle(rd, rpc, iv, rw, dr);
    if (s_req) begin
      mem_busy = 1;
      mem_lat  = (mem_fixed_lat != 0) ? mem_fixed_lat : int'($urandom_range(1, 3));
      mem_word = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_req"}, 32'(imem_req), 32'd0);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " imem_addr"}, imem_addr, 32'd0);
    check({tag, " instr_out"}, instr_out, 32'd0);
    check({tag, " pc_out"}, pc_out, 32'd0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    imem_valid   = 1'b0;
    imem_rdata   = '0;
    decode_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    mem_fixed_lat = 1;
    model_reset();

    // Streaming with 1-cycle memory and decode always ready.
    vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,  1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h4,  1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b1, 32'h11111111, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h22222222, 1'b1, 1'b0, 32'h8,  1'b0, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,  1'b1, 32'h22222222, 32'h4};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'hC,  1'b0, 32'h0,        32'h0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,  1'b1, 32'h33333333, 32'h8};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10, 1'b0, 32'h0,        32'h0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].rd, vecs[i].rpc, vecs[i].iv, vecs[i].rw, vecs[i].dr);
      check("vec imem_req", 32'(s_req), 32'(vecs[i].e_req));
      check("vec imem_addr", s_addr, vecs[i].e_addr);
      check("vec instr_valid", 32'(s_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check("vec instr_out", s_instr, vecs[i].e_instr);
        check("vec pc_out", s_pc, vecs[i].e_pc);
      end
      $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc=%h",
               i, s_req, s_addr, s_valid, s_instr, s_pc);
    end

    // Backpressure: decode stalled, the buffer fills after exactly DEPTH requests.
    do_reset();
    mem_fixed_lat = 1;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      mem_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (s_req) nreq++;
    end
    check("bp request count", 32'(nreq), 32'(DEPTH));
    check("bp full imem_req", 32'(s_req), 32'd0);
    check("bp full head pc", s_pc, 32'h0);
    mem_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp pop valid", 32'(s_valid), 32'd1);
    check("bp pop stalled req", 32'(s_req), 32'd0);
    mem_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("bp next head pc", s_pc, 32'h4);
    check("bp refill req", 32'(s_req), 32'd1);
    check("bp refill addr", s_addr, 32'h10);
    $display("backpressure: %0d requests before full, refill at %h", nreq, s_addr);

    // Redirect while a request is outstanding; late stale response.
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rd issue addr", s_addr, 32'h0);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("rd cycle req", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("discard req 1", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("discard req 2", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("after discard req", 32'(s_req), 32'd1);
    check("after discard addr", s_addr, 32'h100);
    check("stale not presented", 32'(s_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("redirect target pc", s_pc, 32'h100);
    check("redirect target word", s_instr, 32'hCAFEF00D);
    $display("redirect: head pc=%h word=%h", s_pc, s_instr);

    // Redirect, response and pop in the same cycle with two words buffered.
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0,        1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'hA1A1A1A1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0,        1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'hA2A2A2A2, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0,        1'b0);
    check("simul pre addr", s_addr, 32'h8);
    cycle(1'b1, 32'h200, 1'b1, 32'hBADBAD00, 1'b1);
    check("simul pre valid", 32'(s_valid), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("simul flushed", 32'(s_valid), 32'd0);
    check("simul idle req", 32'(s_req), 32'd1);
    check("simul new addr", s_addr, 32'h200);
    cycle(1'b0, 32'h0, 1'b1, 32'h55555555, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("simul new head pc", s_pc, 32'h200);
    check("simul new head word", s_instr, 32'h55555555);
    $display("simultaneous: head pc=%h word=%h", s_pc, s_instr);

    // Address wrap, then asynchronous reset while a request is outstanding.
    do_reset();
    cycle(1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0);
    check("wrap redirect req", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("wrap addr top", s_addr, 32'hFFFFFFFC);
    cycle(1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("wrap addr zero", s_addr, 32'h0);
    check("wrap head pc", s_pc, 32'hFFFFFFFC);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 32'hBAD0BAD0, 1'b0);
    check("post reset req", 32'(s_req), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("late resp ignored", 32'(s_valid), 32'd0);
    $display("wrap/reset: done, valid after late response=%0b", s_valid);

    // Randomized traffic against the reference model.
    do_reset();
    mem_fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] rpc;
      logic        dr;
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      dr  = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mem_cycle(rd, rpc, dr, $urandom_range(0, 19) == 0);
    end
    $display("random: 3000 cycles applied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the fetch PC and issues one word request at a time to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents the head word to decode with a valid/ready handshake.
- Handles branch redirects by flushing the buffer and discarding any stale in-flight response.

Parameters:
- ADDR_W, 32, width of PC and instruction memory address (byte address).
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request strobe; one-cycle pulse per request.
- imem_addr  out  ADDR_W  request address, valid when imem_req=1.
- imem_valid  in  1  response strobe, arrives >=1 cycle after imem_req.
- imem_rdata  in  [0:31]  response word, valid with imem_valid.
- redirect  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  ADDR_W  new fetch address, sampled with redirect.
- instr_valid  out  1  FIFO head valid.
- instr_out  out  [0:31]  FIFO head word, bit 0 = MSB, same ordering as decoder input.
- pc_out  out  ADDR_W  PC of instr_out.
- decode_ready  in  1  decoder accepts head this cycle.

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0), state=IDLE, imem_req=0, instr_valid=0; instr_out and pc_out read 0.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; its response is wanted.
  - DISCARD: one request outstanding; its response is stale.
- Issue (combinational output): imem_req=1 iff state=IDLE && count<DEPTH && !redirect; imem_addr=fetch_pc.
  - On issue: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0), next state WAIT.
- WAIT with imem_valid=1 and no redirect: push {req_pc, imem_rdata}, go to IDLE.
  - The FIFO always has space, because space was reserved at issue and at most one request is outstanding.
  - The next issue can occur in the cycle after the push, giving a sustained rate of 1 word per 2 cycles with 1-cycle memory.
- Output: instr_valid=(count!=0); instr_out and pc_out come from the FIFO head.
  - Pop when instr_valid && decode_ready.
  - Push and pop in the same cycle: count unchanged.
  - A pushed word becomes visible on the next cycle; there is no FIFO bypass.
- Redirect (priority over all other events that cycle):
  - fetch_pc<=redirect_pc and the FIFO is flushed (count=0); any simultaneous push or pop is ignored.
  - instr_valid=0 from the next cycle.
  - Next state from IDLE: IDLE (no issue that cycle).
  - Next state from WAIT: DISCARD if imem_valid=0; IDLE if imem_valid=1 (that word is dropped).
  - Next state from DISCARD: DISCARD if imem_valid=0; IDLE if imem_valid=1 (that word is dropped).
- DISCARD with imem_valid=1: drop the word, no push, go to IDLE.
- imem_valid while in IDLE: protocol violation, ignored (no push, no state change).
- decode_ready while instr_valid=0: no effect.
- Reset mid-operation: immediate return to reset values. A response arriving after reset deasserts while in IDLE is ignored.
- No combinational path from imem_valid or imem_rdata to any output. instr_valid, instr_out and pc_out are registered or FIFO-read only.

Test Plan:
1. Reset check: hold rst_n=0 while toggling clk -> imem_req=0, instr_valid=0, imem_addr=0.
   - Release reset -> first-cycle imem_req=1, imem_addr=0x0.
2. Streaming: memory responds 1 cycle later with words 0x11111111, 0x22222222, 0x33333333; decode_ready=1.
   - Decode sees these words in order with pc_out=0x0, 0x4, 0x8, one every 2 cycles.
3. Backpressure: decode_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req stays 0 and instr_valid=1 with pc_out=0x0.
   - Raise decode_ready for 1 cycle -> one pop, pc_out=0x4, one new request at 0x10.
4. Redirect with outstanding request: redirect=1, redirect_pc=0x100 while in WAIT, response arrives 3 cycles later with 0xDEADBEEF.
   - 0xDEADBEEF is never presented; the next imem_addr is 0x100 and decode receives pc_out=0x100.
5. Simultaneous events: redirect, imem_valid and a pop in the same cycle with count=2.
   - Next cycle count=0, instr_valid=0, returned word dropped, state IDLE, fetch from redirect_pc.
6. Wrap and async reset:
   - redirect_pc=0xFFFFFFFC -> requests at 0xFFFFFFFC then 0x00000000.
   - Assert rst_n=0 mid-WAIT -> outputs return to reset values immediately; a late imem_valid is not pushed.
